// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, instruction field positions and opcode encodings
package cpu_pkg;
   localparam int INSTR_W = 8;
   localparam int PC_W    = 4;
   localparam int OP_HI   = 7;
   localparam int OP_LO   = 5;
   localparam int DST_HI  = 4;
   localparam int DST_LO  = 3;
   localparam int SRC_HI  = 2;
   localparam int SRC_LO  = 1;
   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_AND = 3'b010,
      OP_NOT = 3'b101
   } opcode_t;
   function automatic opcode_t opcode_of(input logic [INSTR_W-1:0] i);
      return opcode_t'(i[OP_HI:OP_LO]);
   endfunction
   function automatic logic [1:0] dest_of(input logic [INSTR_W-1:0] i);
      return i[DST_HI:DST_LO];
   endfunction
   function automatic logic [1:0] src_of(input logic [INSTR_W-1:0] i);
      return i[SRC_HI:SRC_LO];
   endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of {pc, instr} entries with flush and occupancy count
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int PC_W    = cpu_pkg::PC_W,
   parameter int INSTR_W = cpu_pkg::INSTR_W,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = AW + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               push,
   input  logic [PC_W-1:0]    push_pc,
   input  logic [INSTR_W-1:0] push_instr,
   input  logic               pop,
   output logic [PC_W-1:0]    head_pc,
   output logic [INSTR_W-1:0] head_instr,
   output logic [CW-1:0]      count,
   output logic               empty
);
   logic [PC_W-1:0]    pc_mem    [DEPTH];
   logic [INSTR_W-1:0] instr_mem [DEPTH];
   logic [AW-1:0]      rd_ptr, wr_ptr;
   logic               do_push, do_pop;
   // a push into a full queue is only legal when the head leaves in the same cycle
   always_comb begin
      do_pop     = pop && count != '0;
      do_push    = push && (count != CW'(DEPTH) || do_pop);
      empty      = count == '0;
      head_pc    = pc_mem[rd_ptr];
      head_instr = instr_mem[rd_ptr];
   end
   // pointers and occupancy; flush empties the queue and beats any same-cycle push/pop
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
         count  <= count + CW'(do_push) - CW'(do_pop);
      end
   end
   // entry storage, meaningless until pointed at by a valid slot
   always_ff @(posedge clk) begin
      if (do_push) begin
         pc_mem[wr_ptr]    <= push_pc;
         instr_mem[wr_ptr] <= push_instr;
      end
   end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC sequencing, one-cycle memory read tracking and prefetch queue front end
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int PC_W    = cpu_pkg::PC_W,
   parameter int INSTR_W = cpu_pkg::INSTR_W
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_en,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic               halt
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic [PC_W-1:0]    pc, inflight_pc, head_pc;
   logic [INSTR_W-1:0] head_instr;
   logic [CW-1:0]      q_count;
   logic               inflight, q_empty;
   // issue only when the queue can absorb every outstanding response; outputs come from queue state
   always_comb begin
      imem_en     = !reset && !halt && !redirect_valid && (q_count + CW'(inflight) < CW'(DEPTH));
      imem_addr   = reset ? '0 : pc;
      instr_valid = !reset && !q_empty;
      instr       = instr_valid ? head_instr : '0;
      instr_pc    = instr_valid ? head_pc : '0;
   end
   // fetch PC and the single read whose data returns next cycle (never set under reset/redirect)
   always_ff @(posedge clk) begin
      pc          <= reset ? '0 : redirect_valid ? redirect_pc : imem_en ? pc + PC_W'(1) : pc;
      inflight    <= imem_en;
      inflight_pc <= pc;
   end
   fetch_queue #(
      .DEPTH  (DEPTH),
      .PC_W   (PC_W),
      .INSTR_W(INSTR_W)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (inflight),
      .push_pc   (inflight_pc),
      .push_instr(imem_rdata),
      .pop       (instr_valid && instr_ready),
      .head_pc   (head_pc),
      .head_instr(head_instr),
      .count     (q_count),
      .empty     (q_empty)
   );
endmodule
